fabric_tag_interleaver: RTL and testbench
=========================================

// Module: fabric_tag_interleaver
// PURPOSE
//  Transmit side of the tagged-stream interface that feeds temporal PEs.
//  Merges NUM_INPUTS untagged value streams into one tagged stream {tag, value}.
//  Each input lane carries a configured tag. Lanes are picked by round-robin
//  arbitration, and the output is buffered so the merged stream runs at 1 token/cycle.
//  Sits upstream of a temporal PE input port; config is driven by the fabric config chain.
// PARAMETERS
//  NUM_INPUTS   4   number of untagged input lanes (>=2)
//  DATA_WIDTH   32  value width per token (>=1)
//  TAG_WIDTH    4   tag width (>=1)
//  FIFO_DEPTH   2   output buffer entries (>=2, power of 2)
//  localparam PAYLOAD_WIDTH = DATA_WIDTH+TAG_WIDTH
//  localparam CONFIG_WIDTH  = NUM_INPUTS*(1+TAG_WIDTH)
// PORTS
//  clk          in   1                       clock
//  rst          in   1                       synchronous reset, active-high
//  in_valid     in   NUM_INPUTS              per-lane valid
//  in_ready     out  NUM_INPUTS              per-lane ready
//  in_data      in   NUM_INPUTS x DATA_WIDTH per-lane value
//  out_valid    out  1                       tagged token valid
//  out_ready    in   1                       downstream ready
//  out_data     out  PAYLOAD_WIDTH           {tag[TAG_WIDTH-1:0], value[DATA_WIDTH-1:0]}
//  cfg_data     in   CONFIG_WIDTH            lane i at [i*(1+TW) +: 1+TW] = {en, tag}
//  error_valid  out  1                       sticky error flag
//  error_code   out  16                      first captured error code
// BEHAVIOUR
//  Clock/reset: one clock; reset is synchronous and active-high.
//  Reset: out_valid=0, in_ready=0, error_valid=0, error_code=0, FIFO empty, rr_ptr=0.
//  Elaboration: $fatal on NUM_INPUTS<2, TAG_WIDTH<1, or FIFO_DEPTH<2 / not power of 2.
//  Eligibility: lane i is eligible iff en[i] && in_valid[i].
//  Arbitration: grant the first eligible lane scanning rr_ptr, rr_ptr+1, ... (mod NUM_INPUTS).
//  in_ready:
//   - in_ready[i] = grant[i] && !fifo_full; all other lanes see 0.
//   - in_ready is combinational on in_valid; a lane never sees ready unless it is granted.
//  Accept: on in_valid[i] && in_ready[i],
//   - push {tag[i], in_data[i]} to the FIFO;
//   - rr_ptr <= (i+1) mod NUM_INPUTS; rr_ptr holds when there is no accept.
//  Output:
//   - out_valid = !fifo_empty; out_data = FIFO head.
//   - Pop on out_valid && out_ready.
//   - Latency: accept in cycle N -> out_valid in cycle N+1 (FIFO was empty).
//  Simultaneous push+pop when full: push blocked, because in_ready is computed from
//   fifo_full, not from the pop. Push+pop at any other level: count unchanged.
//  Pointers: FIFO wr/rd pointers wrap modulo FIFO_DEPTH; count range is 0..FIFO_DEPTH.
//  Ordering: per-lane token order is preserved; cross-lane order follows grant order.
//  Tag field: copied verbatim from config, with no arithmetic; value bits pass unmodified.
//  Config changes: cfg_data is static while tokens are in flight. Tokens already in
//   the FIFO keep the tag they were given at accept time.
//  Errors (lowest code wins when several fire in one cycle):
//   - CFG_TAG_INTERLEAVER_DUP_TAG: two enabled lanes share a tag.
//   - RT_TAG_INTERLEAVER_DISABLED_LANE: in_valid[i] && !en[i]. That lane stays stalled.
//   - Latch: captured on the first cycle with !error_valid; held until rst.
//     Later errors are ignored.
//   - Data flow continues after an error.
//  Reset mid-operation: FIFO contents discarded, out_valid drops in the cycle after rst,
//   rr_ptr returns to 0.
// STRUCTURE
//  fabric_common.svh / fabric_pkg gets two error-code constants:
//   CFG_TAG_INTERLEAVER_DUP_TAG, RT_TAG_INTERLEAVER_DISABLED_LANE.
//  fabric_pkg gets a lane-config struct typedef: {logic en; logic [TW-1:0] tag}.
//  Sub-module fabric_sync_fifo (DEPTH, WIDTH): push/pop/full/empty, sync active-high rst.
//  The arbiter stays inline (rotate, priority-encode, rotate back).
// TESTING
//  1. Single lane: 4 lanes en, tags 3,5,7,9; lane1 sends 0xA5, out_ready=1
//     -> out_data={4'h5,32'hA5} one cycle later.
//  2. All lanes valid continuously, out_ready=1
//     -> grants 0,1,2,3,0,... at 1 token/cycle; out tags 3,5,7,9,...
//  3. Backpressure: out_ready=0 with all lanes valid -> exactly FIFO_DEPTH accepts,
//     then in_ready=0; release -> same order, no loss, no duplicates.
//  4. Duplicate tags: lanes 0 and 2 both tag 6, both en
//     -> error_valid=1 next cycle, error_code=CFG_TAG_INTERLEAVER_DUP_TAG, stays set.
//  5. Disabled lane: en[3]=0, in_valid[3]=1 -> in_ready[3] never 1,
//     error_code=RT_TAG_INTERLEAVER_DISABLED_LANE; other lanes keep flowing.
//  6. Reset mid-stream: assert rst with FIFO holding 2 tokens -> out_valid=0,
//     error cleared, first grant after reset is the lowest-index eligible lane.

Source files
------------

// File: rtl/fabric_pkg.sv
// Shared fabric definitions: error codes and the per-lane tag configuration record.
package fabric_pkg;

  localparam int TAG_WIDTH_MAX = 16;

  localparam logic [15:0] CFG_TAG_INTERLEAVER_DUP_TAG      = 16'h0011;
  localparam logic [15:0] RT_TAG_INTERLEAVER_DISABLED_LANE = 16'h0104;

  // Tags narrower than TAG_WIDTH_MAX are zero-extended into this record.
  typedef struct packed {
    logic                     en;
    logic [TAG_WIDTH_MAX-1:0] tag;
  } lane_cfg_t;

  function automatic logic [15:0] min_code(input logic [15:0] a, input logic [15:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/fabric_sync_fifo.sv
// Single-clock FIFO with registered pointers and an occupancy counter.
module fabric_sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full_o     = (cnt_q == CW'(DEPTH));
    empty_o    = (cnt_q == '0);
    do_push    = push_i && !full_o;
    do_pop     = pop_i && !empty_o;
    wr_d       = do_push ? wr_q + AW'(1) : wr_q;
    rd_d       = do_pop ? rd_q + AW'(1) : rd_q;
    cnt_d      = cnt_q + CW'(do_push) - CW'(do_pop);
    pop_data_o = mem_q[rd_q];
  end

  // Power-of-two depth lets the pointers wrap on natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/fabric_tag_interleaver.sv
// Merges untagged lanes into one {tag, value} stream via round-robin arbitration
// into a small output FIFO; flags duplicate tags and valid on disabled lanes.
module fabric_tag_interleaver
  import fabric_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int FIFO_DEPTH = 2,
  localparam int PAYLOAD_WIDTH = DATA_WIDTH + TAG_WIDTH,
  localparam int CONFIG_WIDTH  = NUM_INPUTS * (1 + TAG_WIDTH)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_INPUTS-1:0]              in_valid,
  output logic [NUM_INPUTS-1:0]              in_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]   in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [PAYLOAD_WIDTH-1:0]           out_data,
  input  logic [CONFIG_WIDTH-1:0]            cfg_data,
  output logic                               error_valid,
  output logic [15:0]                        error_code
);

  localparam int                LANE_CFG_W = 1 + TAG_WIDTH;
  localparam int                PTR_W      = $clog2(NUM_INPUTS);
  localparam logic [PTR_W:0]    SUM_N      = (PTR_W + 1)'(NUM_INPUTS);

  if (NUM_INPUTS < 2) begin : g_bad_inputs
    $fatal(1, "fabric_tag_interleaver: NUM_INPUTS must be >= 2");
  end
  if (DATA_WIDTH < 1) begin : g_bad_data
    $fatal(1, "fabric_tag_interleaver: DATA_WIDTH must be >= 1");
  end
  if (TAG_WIDTH < 1 || TAG_WIDTH > TAG_WIDTH_MAX) begin : g_bad_tag
    $fatal(1, "fabric_tag_interleaver: TAG_WIDTH out of range");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "fabric_tag_interleaver: FIFO_DEPTH must be a power of 2 >= 2");
  end

  lane_cfg_t                cfg_lane [NUM_INPUTS];
  logic [NUM_INPUTS-1:0]    eligible;
  logic [NUM_INPUTS-1:0]    stray_valid;
  logic [NUM_INPUTS-1:0]    rotated;
  logic [NUM_INPUTS-1:0]    grant;
  logic [PTR_W-1:0]         offset;
  logic [PTR_W-1:0]         grant_idx;
  logic [PTR_W:0]           grant_sum;
  logic [PTR_W:0]           next_sum;
  logic                     any_elig;
  logic [PTR_W-1:0]         rr_q, rr_d;
  logic                     accept;
  logic [PAYLOAD_WIDTH-1:0] push_data;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     dup_tag;
  logic [15:0]              fire_code;
  logic                     err_valid_q, err_valid_d;
  logic [15:0]              err_code_q, err_code_d;

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      cfg_lane[i].en  = cfg_data[i*LANE_CFG_W + TAG_WIDTH];
      cfg_lane[i].tag = TAG_WIDTH_MAX'(cfg_data[i*LANE_CFG_W +: TAG_WIDTH]);
      eligible[i]     = cfg_lane[i].en && in_valid[i];
      stray_valid[i]  = in_valid[i] && !cfg_lane[i].en;
    end
  end

  // Rotate so rr_q sits at bit 0, pick the lowest set bit, rotate the index back.
  always_comb begin
    rotated  = NUM_INPUTS'({eligible, eligible} >> rr_q);
    offset   = '0;
    any_elig = 1'b0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        offset   = PTR_W'(k);
        any_elig = 1'b1;
      end
    end
    grant_sum = {1'b0, rr_q} + {1'b0, offset};
    if (grant_sum >= SUM_N) begin
      grant_sum = grant_sum - SUM_N;
    end
    grant_idx = grant_sum[PTR_W-1:0];
    grant     = '0;
    if (any_elig) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Handshake: a lane transfers on a cycle with in_valid && in_ready. in_ready
  // depends combinationally on in_valid (through the grant) but in_valid must
  // never wait on in_ready. The output side transfers on out_valid && out_ready.
  always_comb begin
    in_ready  = grant & {NUM_INPUTS{!fifo_full && !rst}};
    accept    = |(in_valid & in_ready);
    push_data = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant[i]) begin
        push_data = {cfg_lane[i].tag[TAG_WIDTH-1:0], in_data[i*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
    next_sum = {1'b0, grant_idx} + (PTR_W + 1)'(1);
    if (next_sum >= SUM_N) begin
      next_sum = next_sum - SUM_N;
    end
    rr_d = accept ? next_sum[PTR_W-1:0] : rr_q;
  end

  always_comb begin
    dup_tag = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      for (int j = i + 1; j < NUM_INPUTS; j++) begin
        if (cfg_lane[i].en && cfg_lane[j].en && (cfg_lane[i].tag == cfg_lane[j].tag)) begin
          dup_tag = 1'b1;
        end
      end
    end
  end

  // When several errors fire together the numerically lowest code is captured.
  always_comb begin
    fire_code = 16'hFFFF;
    if (dup_tag) begin
      fire_code = min_code(fire_code, CFG_TAG_INTERLEAVER_DUP_TAG);
    end
    if (|stray_valid) begin
      fire_code = min_code(fire_code, RT_TAG_INTERLEAVER_DISABLED_LANE);
    end
    err_valid_d = err_valid_q;
    err_code_d  = err_code_q;
    if (!err_valid_q && (dup_tag || |stray_valid)) begin
      err_valid_d = 1'b1;
      err_code_d  = fire_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q        <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      rr_q        <= rr_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  fabric_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PAYLOAD_WIDTH)
  ) u_out_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (accept),
    .push_data_i (push_data),
    .pop_i       (out_ready),
    .pop_data_o  (out_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign out_valid   = !fifo_empty;
  assign error_valid = err_valid_q;
  assign error_code  = err_code_q;

endmodule

// File: tb/tb_fabric_tag_interleaver.sv
// Directed bench for fabric_tag_interleaver: queue-based reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_fabric_tag_interleaver;
  import fabric_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int TW    = 4;
  localparam int DEPTH = 2;
  localparam int PW    = DW + TW;
  localparam int CW    = N * (1 + TW);

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N*DW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [PW-1:0]   out_data;
  logic [CW-1:0]   cfg_data;
  logic            error_valid;
  logic [15:0]     error_code;

  fabric_tag_interleaver #(
    .NUM_INPUTS (N),
    .DATA_WIDTH (DW),
    .TAG_WIDTH  (TW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .cfg_data    (cfg_data),
    .error_valid (error_valid),
    .error_code  (error_code)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic f_en(input int l);
    return cfg_data[l*(1+TW) + TW];
  endfunction

  function automatic logic [TW-1:0] f_tag(input int l);
    return cfg_data[l*(1+TW) +: TW];
  endfunction

  // ---------------- reference model / scoreboard ----------------
  logic [PW-1:0] exp_q[$];
  int            m_rr      = 0;
  logic          m_err_v   = 1'b0;
  logic [15:0]   m_err_c   = '0;
  logic [N-1:0]  hs_mask   = '0;
  int            hs_count  = 0;
  bit            rdy3_seen = 1'b0;

  always @(negedge clk) begin : compare_p
    logic [N-1:0] exp_rdy;
    bit           found;
    bit           pop_now;
    bit           dup;
    bit           dis;
    int           gl;
    int           l;
    logic [15:0]  code;
    exp_rdy = '0;
    found   = 1'b0;
    gl      = 0;
    if (!rst && exp_q.size() < DEPTH) begin
      for (int k = 0; k < N; k++) begin
        l = (m_rr + k) % N;
        if (!found && f_en(l) && in_valid[l]) begin
          exp_rdy[l] = 1'b1;
          found      = 1'b1;
          gl         = l;
        end
      end
    end
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("out_data", 64'(out_data), 64'(exp_q[0]));
    check("error_valid", 64'(error_valid), 64'(m_err_v));
    check("error_code", 64'(error_code), 64'(m_err_c));
    hs_mask  = in_valid & in_ready;
    hs_count += $countones(hs_mask);
    if (in_ready[3]) rdy3_seen = 1'b1;
    if (rst) begin
      exp_q.delete();
      m_rr    = 0;
      m_err_v = 1'b0;
      m_err_c = '0;
    end else begin
      pop_now = (exp_q.size() != 0) && out_ready;
      if (found) begin
        exp_q.push_back({f_tag(gl), in_data[gl*DW +: DW]});
        m_rr = (gl + 1) % N;
      end
      if (pop_now) void'(exp_q.pop_front());
      dup = 1'b0;
      dis = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (in_valid[i] && !f_en(i)) dis = 1'b1;
        for (int j = i + 1; j < N; j++)
          if (f_en(i) && f_en(j) && f_tag(i) == f_tag(j)) dup = 1'b1;
      end
      code = 16'hFFFF;
      if (dup && CFG_TAG_INTERLEAVER_DUP_TAG < code) code = CFG_TAG_INTERLEAVER_DUP_TAG;
      if (dis && RT_TAG_INTERLEAVER_DISABLED_LANE < code) code = RT_TAG_INTERLEAVER_DISABLED_LANE;
      if (!m_err_v && (dup || dis)) begin
        m_err_v = 1'b1;
        m_err_c = code;
      end
    end
  end

  // ---------------- driver tasks ----------------
  bit auto_data = 1'b0;
  int seq [N];

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_data) begin
      for (int l = 0; l < N; l++) begin
        if (hs_mask[l]) begin
          seq[l]++;
          in_data[l*DW +: DW] = (32'(l) << 16) | 32'(seq[l]);
        end
      end
    end
  endtask

  task automatic at_sample();
    @(negedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [N-1:0] en, input logic [N*TW-1:0] tags);
    for (int l = 0; l < N; l++) cfg_data[l*(1+TW) +: (1+TW)] = {en[l], tags[l*TW +: TW]};
  endtask

  task automatic reset_dut();
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = 1'b1;
    auto_data = 1'b0;
    for (int l = 0; l < N; l++) begin
      seq[l] = 0;
      in_data[l*DW +: DW] = 32'(l) << 16;
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    in_valid  = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 16 && exp_q.size() != 0; c++) tick();
    at_sample();
    check("drain_out_valid", 64'(out_valid), 64'(0));
    tick();
  endtask

  // ---------------- directed scenarios ----------------
  localparam logic [N*TW-1:0] TAGS_STD = {4'h9, 4'h7, 4'h5, 4'h3};
  localparam logic [N*TW-1:0] TAGS_DUP = {4'h9, 4'h6, 4'h5, 4'h6};

  initial begin : stim_p
    int            hs0;
    logic [TW-1:0] tag_tbl [N];
    tag_tbl   = '{4'h3, 4'h5, 4'h7, 4'h9};
    cfg_data  = '0;
    in_data   = '0;
    set_cfg('1, TAGS_STD);
    reset_dut();

    // reset state
    at_sample();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_error_valid", 64'(error_valid), 64'(0));
    check("rst_error_code", 64'(error_code), 64'(0));
    tick();

    // single lane, one-cycle latency
    in_valid = 4'b0010;
    in_data[1*DW +: DW] = 32'hA5;
    at_sample();
    check("t1_in_ready", 64'(in_ready), 64'(4'b0010));
    tick();
    in_valid = '0;
    at_sample();
    check("t1_out_valid", 64'(out_valid), 64'(1));
    check("t1_out_data", 64'(out_data), 64'({4'h5, 32'hA5}));
    tick();
    drain();

    // all lanes streaming at full rate
    reset_dut();
    set_cfg('1, TAGS_STD);
    in_valid  = '1;
    auto_data = 1'b1;
    for (int k = 0; k < 9; k++) begin
      at_sample();
      if (k >= 1) begin
        check("t2_out_valid", 64'(out_valid), 64'(1));
        check("t2_out_data", 64'(out_data),
              64'({tag_tbl[(k-1)%N], (32'((k-1)%N) << 16) | 32'((k-1)/N)}));
      end
      tick();
    end
    drain();

    // backpressure fills exactly FIFO_DEPTH entries
    reset_dut();
    set_cfg('1, TAGS_STD);
    out_ready = 1'b0;
    in_valid  = '1;
    auto_data = 1'b1;
    hs0 = hs_count;
    repeat (5) tick();
    at_sample();
    check("t3_accepts", 64'(hs_count - hs0), 64'(DEPTH));
    check("t3_in_ready_full", 64'(in_ready), 64'(0));
    tick();
    out_ready = 1'b1;
    at_sample();
    check("t3_head0", 64'(out_data), 64'({4'h3, 32'h0000_0000}));
    check("t3_blocked_on_pop", 64'(in_ready), 64'(0));
    tick();
    at_sample();
    check("t3_head1", 64'(out_data), 64'({4'h5, 32'h0001_0000}));
    tick();
    repeat (4) tick();
    drain();

    // duplicate tags
    reset_dut();
    set_cfg('1, TAGS_DUP);
    at_sample();
    check("t4_err_not_yet", 64'(error_valid), 64'(0));
    tick();
    at_sample();
    check("t4_err_valid", 64'(error_valid), 64'(1));
    check("t4_err_code", 64'(error_code), 64'(CFG_TAG_INTERLEAVER_DUP_TAG));
    repeat (3) tick();
    at_sample();
    check("t4_err_sticky", 64'(error_code), 64'(CFG_TAG_INTERLEAVER_DUP_TAG));
    tick();

    // duplicate tag and disabled-lane valid in the same cycle
    reset_dut();
    set_cfg(4'b0111, TAGS_DUP);
    in_valid = 4'b1000;
    at_sample();
    check("t4b_in_ready", 64'(in_ready), 64'(0));
    tick();
    at_sample();
    check("t4b_lowest_code", 64'(error_code), 64'(CFG_TAG_INTERLEAVER_DUP_TAG));
    tick();
    drain();

    // disabled lane stays stalled while others flow
    reset_dut();
    set_cfg(4'b0111, TAGS_STD);
    in_valid  = '1;
    auto_data = 1'b1;
    rdy3_seen = 1'b0;
    hs0 = hs_count;
    repeat (12) tick();
    at_sample();
    check("t5_lane3_never_ready", 64'(rdy3_seen), 64'(0));
    check("t5_flow", 64'(hs_count - hs0), 64'(13));
    check("t5_err_code", 64'(error_code), 64'(RT_TAG_INTERLEAVER_DISABLED_LANE));
    tick();
    drain();

    // reset with tokens in flight and an error latched
    reset_dut();
    set_cfg(4'b0111, TAGS_STD);
    out_ready = 1'b0;
    in_valid  = '1;
    auto_data = 1'b1;
    hs0 = hs_count;
    repeat (3) tick();
    at_sample();
    check("t6_pre_accepts", 64'(hs_count - hs0), 64'(2));
    check("t6_pre_out_valid", 64'(out_valid), 64'(1));
    check("t6_pre_error", 64'(error_valid), 64'(1));
    tick();
    rst      = 1'b1;
    in_valid = 4'b0110;
    at_sample();
    check("t6_in_ready_in_rst", 64'(in_ready), 64'(0));
    tick();
    rst = 1'b0;
    at_sample();
    check("t6_out_valid", 64'(out_valid), 64'(0));
    check("t6_error_cleared", 64'(error_valid), 64'(0));
    check("t6_first_grant", 64'(in_ready), 64'(4'b0010));
    tick();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog_p
    #50000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
